// File: rtl/uart_tx_arbiter_if.sv
// Requester and UART-side handshake bundle for uart_tx_arbiter.
// The master modport is the environment (byte sources plus UART core); slave is the arbiter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          tx_start;
  logic [DATA_WIDTH-1:0]         tx_data;
  logic                          tx_active;
  logic                          tx_done;

  modport master (
    output req_valid, req_data, req_last, tx_active, tx_done,
    input  req_ready, tx_start, tx_data
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_active, tx_done,
    output req_ready, tx_start, tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-granular arbiter sharing one UART transmitter among NUM_REQ byte sources.
// Optional build macro UART_ARB_FIXED_PRIO_EN: lowest-index-wins instead of round-robin.
module uart_tx_arbiter #(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int MAX_BURST  = 16,
  localparam int IDW        = $clog2(NUM_REQ)
) (
  input  logic               clock,
  input  logic               reset,
  uart_tx_arbiter_if.slave   bus,
  output logic [IDW-1:0]     grant_id,
  output logic               busy
);

  localparam int                 IDW1      = IDW + 1;
  localparam logic [7:0]         BURST_LIM = 8'(MAX_BURST);
  localparam logic [NUM_REQ-1:0] ONE_HOT0  = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GRANT     = 3'd1,
    ST_LOAD      = 3'd2,
    ST_WAIT_ACT  = 3'd3,
    ST_WAIT_DONE = 3'd4
  } state_e;

  state_e                  state_q,     state_d;
  logic [IDW-1:0]          ptr_q,       ptr_d;
  logic [IDW-1:0]          grant_q,     grant_d;
  logic [7:0]              burst_q,     burst_d;
  logic                    last_q,      last_d;
  logic [NUM_REQ-1:0]      req_ready_q, req_ready_d;
  logic                    tx_start_q,  tx_start_d;
  logic [DATA_WIDTH-1:0]   tx_data_q,   tx_data_d;
  logic                    busy_q,      busy_d;

  logic [IDW-1:0]          pick_s;
  logic [IDW-1:0]          next_id_s;
  logic [NUM_REQ-1:0]      grant_onehot_s;
  logic                    release_s;
  logic [DATA_WIDTH-1:0]   sel_byte_s;

`ifdef UART_ARB_FIXED_PRIO_EN
  function automatic logic [IDW-1:0] pick_winner(input logic [NUM_REQ-1:0] valid,
                                                 input logic [IDW-1:0]     ptr);
    logic [IDW-1:0] pick;
    pick = ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (valid[i]) begin
        pick = IDW'(i);
      end
    end
    return pick;
  endfunction
`else
  // Scan from the farthest offset down so the last hit is the nearest valid index at/after ptr.
  function automatic logic [IDW-1:0] pick_winner(input logic [NUM_REQ-1:0] valid,
                                                 input logic [IDW-1:0]     ptr);
    logic [IDW-1:0] pick;
    logic [IDW:0]   idx;
    pick = ptr;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      idx = {1'b0, ptr} + IDW1'(off);
      if (idx >= IDW1'(NUM_REQ)) begin
        idx = idx - IDW1'(NUM_REQ);
      end
      if (valid[idx[IDW-1:0]]) begin
        pick = idx[IDW-1:0];
      end
    end
    return pick;
  endfunction
`endif

  function automatic logic [DATA_WIDTH-1:0] select_byte(input logic [NUM_REQ*DATA_WIDTH-1:0] data,
                                                        input logic [IDW-1:0]                sel);
    logic [DATA_WIDTH-1:0] b;
    b = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel == IDW'(i)) begin
        b = data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    return b;
  endfunction

  assign pick_s         = pick_winner(bus.req_valid, ptr_q);
  assign next_id_s      = (grant_q == IDW'(NUM_REQ - 1)) ? {IDW{1'b0}} : grant_q + IDW'(1);
  assign grant_onehot_s = ONE_HOT0 << grant_q;
  assign release_s      = last_q || (burst_q == BURST_LIM);
  assign sel_byte_s     = select_byte(bus.req_data, grant_q);

  // Next-state and next-output computation for the packet sequencer.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    burst_d     = burst_q;
    last_d      = last_q;
    tx_data_d   = tx_data_q;
    req_ready_d = {NUM_REQ{1'b0}};
    tx_start_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|bus.req_valid) begin
          grant_d     = pick_s;
          burst_d     = 8'd0;
          req_ready_d = ONE_HOT0 << pick_s;
          state_d     = ST_GRANT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (bus.req_valid[grant_q]) begin
          tx_data_d  = sel_byte_s;
          last_d     = bus.req_last[grant_q];
          burst_d    = burst_q + 8'd1;
          tx_start_d = 1'b1;
          state_d    = ST_LOAD;
        end else begin
          ptr_d   = next_id_s;
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        state_d = ST_WAIT_ACT;
      end
      // A done pulse that beats tx_active still completes the byte.
      ST_WAIT_ACT: begin
        if (bus.tx_done) begin
          if (release_s) begin
            ptr_d   = next_id_s;
            state_d = ST_IDLE;
          end else begin
            req_ready_d = grant_onehot_s;
            state_d     = ST_GRANT;
          end
        end else if (bus.tx_active) begin
          state_d = ST_WAIT_DONE;
        end else begin
          state_d = ST_WAIT_ACT;
        end
      end
      ST_WAIT_DONE: begin
        if (bus.tx_done) begin
          if (release_s) begin
            ptr_d   = next_id_s;
            state_d = ST_IDLE;
          end else begin
            req_ready_d = grant_onehot_s;
            state_d     = ST_GRANT;
          end
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered-output flops.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= {IDW{1'b0}};
      grant_q     <= {IDW{1'b0}};
      burst_q     <= 8'd0;
      last_q      <= 1'b0;
      req_ready_q <= {NUM_REQ{1'b0}};
      tx_start_q  <= 1'b0;
      tx_data_q   <= {DATA_WIDTH{1'b0}};
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      burst_q     <= burst_d;
      last_q      <= last_d;
      req_ready_q <= req_ready_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.tx_start  = tx_start_q;
  assign bus.tx_data   = tx_data_q;
  assign grant_id      = grant_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester driver, UART model and a tx_start monitor.
// Expected byte order is hand-derived per scenario and queued before the traffic runs.
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] grant_id;
  logic       busy;

  always #5 clock = ~clock;

  uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus),
    .grant_id (grant_id),
    .busy     (busy)
  );

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [8:0] rq[NR][$];
  logic [NR-1:0] wd = '0;
  logic       flush = 1'b0;
  logic       uart_early = 1'b0;
  logic       uart_busy = 1'b0;
  int         checks = 0;
  int         failures = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  task automatic push_byte(int r, logic [7:0] d, logic last);
    rq[r].push_back({last, d});
  endtask

  task automatic expect_byte(logic [1:0] id, logic [7:0] d);
    exp_q.push_back('{id: id, data: d});
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NR; i++) begin
      if (rq[i].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic wait_idle(string name);
    int n;
    n = 0;
    repeat (3) @(negedge clock);
    while (n < 400 && !(exp_q.size() == 0 && all_empty() && !uart_busy && !busy)) begin
      @(negedge clock);
      n++;
    end
    chk({name, "_drained"}, (n < 400), 1);
  endtask

  // Requesters: present queue heads, retire a byte the negedge after its accept.
  initial begin
    logic [NR-1:0]    pend;
    logic [NR-1:0]    v;
    logic [NR-1:0]    l;
    logic [NR*DW-1:0] d;
    pend = '0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    forever begin
      @(negedge clock);
      if (flush) begin
        for (int i = 0; i < NR; i++) rq[i].delete();
        pend = '0;
      end else begin
        for (int i = 0; i < NR; i++) begin
          if (pend[i] && rq[i].size() > 0) void'(rq[i].pop_front());
          pend[i] = 1'b0;
          if (bus.req_ready[i] && bus.req_valid[i] && rq[i].size() > 0) begin
            if (wd[i]) void'(rq[i].pop_front());
            else pend[i] = 1'b1;
          end
        end
      end
      v = '0; l = '0; d = '0;
      for (int i = 0; i < NR; i++) begin
        if (rq[i].size() > 0) begin
          v[i] = 1'b1;
          d[i*DW +: DW] = rq[i][0][7:0];
          l[i] = rq[i][0][8];
        end
      end
      bus.req_valid = v;
      bus.req_data  = d;
      bus.req_last  = l;
    end
  end

  // UART core model: active for a few cycles then a done pulse; early mode skips tx_active.
  initial begin
    bus.tx_active = 1'b0;
    bus.tx_done   = 1'b0;
    forever begin
      @(negedge clock);
      if (bus.tx_start) begin
        uart_busy = 1'b1;
        repeat (2) @(negedge clock);
        if (!uart_early) begin
          bus.tx_active = 1'b1;
          repeat (3) @(negedge clock);
          bus.tx_active = 1'b0;
        end
        bus.tx_done = 1'b1;
        @(negedge clock);
        bus.tx_done = 1'b0;
        uart_busy = 1'b0;
      end
    end
  end

  // Monitor: every launched character is popped from the scoreboard and compared.
  initial begin
    logic [7:0] last_d;
    logic       acc_prev;
    exp_t       e;
    last_d = 8'h00;
    acc_prev = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        last_d = 8'h00;
        acc_prev = 1'b0;
      end else begin
        chk("ready_onehot", ($countones(bus.req_ready) <= 1), 1);
        if (bus.tx_start) begin
          chk("start_expected", (exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("tx_data", bus.tx_data, e.data);
            chk("grant_id", grant_id, e.id);
          end
          chk("start_after_accept", acc_prev, 1);
          last_d = bus.tx_data;
        end else begin
          chk("tx_data_hold", bus.tx_data, last_d);
        end
        acc_prev = |(bus.req_ready & bus.req_valid);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    repeat (3) @(negedge clock);
    chk("rst_req_ready", bus.req_ready, 4'b0000);
    chk("rst_tx_start", bus.tx_start, 1'b0);
    chk("rst_tx_data", bus.tx_data, 8'h00);
    chk("rst_grant_id", grant_id, 2'd0);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b1;
    @(negedge clock);

    // Single requester, 3-byte packet; pointer ends at 2.
    push_byte(1, 8'hA1, 1'b0); push_byte(1, 8'hA2, 1'b0); push_byte(1, 8'hA3, 1'b1);
    expect_byte(2'd1, 8'hA1); expect_byte(2'd1, 8'hA2); expect_byte(2'd1, 8'hA3);
    wait_idle("single");
    chk("single_grant_hold", grant_id, 2'd1);
    chk("single_busy_low", busy, 1'b0);

    // Three 1-byte packets at once: from pointer 2 the order is 2,3,0.
    push_byte(0, 8'h10, 1'b1); push_byte(2, 8'h20, 1'b1); push_byte(3, 8'h30, 1'b1);
`ifdef UART_ARB_FIXED_PRIO_EN
    expect_byte(2'd0, 8'h10); expect_byte(2'd2, 8'h20); expect_byte(2'd3, 8'h30);
`else
    expect_byte(2'd2, 8'h20); expect_byte(2'd3, 8'h30); expect_byte(2'd0, 8'h10);
`endif
    wait_idle("rr");

    // Re-request 0 and 3 from pointer 1: wrap gives 3 then 0.
    push_byte(0, 8'h11, 1'b1); push_byte(3, 8'h31, 1'b1);
`ifdef UART_ARB_FIXED_PRIO_EN
    expect_byte(2'd0, 8'h11); expect_byte(2'd3, 8'h31);
`else
    expect_byte(2'd3, 8'h31); expect_byte(2'd0, 8'h11);
`endif
    wait_idle("rr_wrap");

    // Burst limit 4: req1 6-byte packet interleaved with req2's packet.
    for (int i = 0; i < 6; i++) push_byte(1, 8'hB0 + 8'(i), (i == 5));
    push_byte(2, 8'hC0, 1'b1);
    for (int i = 0; i < 4; i++) expect_byte(2'd1, 8'hB0 + 8'(i));
`ifdef UART_ARB_FIXED_PRIO_EN
    expect_byte(2'd1, 8'hB4); expect_byte(2'd1, 8'hB5); expect_byte(2'd2, 8'hC0);
`else
    expect_byte(2'd2, 8'hC0); expect_byte(2'd1, 8'hB4); expect_byte(2'd1, 8'hB5);
`endif
    wait_idle("burst");

    // Withdrawal: req2 drops its byte when granted; no launch, pointer becomes 3.
    wd[2] = 1'b1;
    push_byte(2, 8'hDD, 1'b1);
    n = 0;
    while (n < 20 && !bus.req_ready[2]) begin
      @(negedge clock);
      n++;
    end
    chk("wd_ready", bus.req_ready, 4'b0100);
    chk("wd_grant_id", grant_id, 2'd2);
    chk("wd_busy", busy, 1'b1);
    wait_idle("withdraw");
    wd[2] = 1'b0;
    push_byte(0, 8'h40, 1'b1); push_byte(2, 8'h42, 1'b1); push_byte(3, 8'h43, 1'b1);
`ifdef UART_ARB_FIXED_PRIO_EN
    expect_byte(2'd0, 8'h40); expect_byte(2'd2, 8'h42); expect_byte(2'd3, 8'h43);
`else
    expect_byte(2'd3, 8'h43); expect_byte(2'd0, 8'h40); expect_byte(2'd2, 8'h42);
`endif
    wait_idle("after_wd");

    // Early tx_done with tx_active never asserted.
    uart_early = 1'b1;
    push_byte(3, 8'hE0, 1'b0); push_byte(3, 8'hE1, 1'b1);
    expect_byte(2'd3, 8'hE0); expect_byte(2'd3, 8'hE1);
    wait_idle("early_done");
    uart_early = 1'b0;

    // Move pointer to 2, then reset in the middle of req2's first byte.
    push_byte(1, 8'h51, 1'b1);
    expect_byte(2'd1, 8'h51);
    wait_idle("pre_reset");
    push_byte(2, 8'h60, 1'b0); push_byte(2, 8'h61, 1'b1);
    expect_byte(2'd2, 8'h60);
    n = 0;
    while (n < 50 && !bus.tx_active) begin
      @(negedge clock);
      n++;
    end
    chk("mid_active_seen", bus.tx_active, 1'b1);
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_req_ready", bus.req_ready, 4'b0000);
    chk("mid_rst_tx_start", bus.tx_start, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_grant_id", grant_id, 2'd0);
    chk("mid_rst_tx_data", bus.tx_data, 8'h00);
    flush = 1'b1;
    repeat (12) @(negedge clock);
    flush = 1'b0;
    @(negedge clock);
    #2 reset = 1'b1;
    @(negedge clock);
    // Pointer restarted at 0: order 0 then 3.
    push_byte(0, 8'h70, 1'b1); push_byte(3, 8'h73, 1'b1);
    expect_byte(2'd0, 8'h70); expect_byte(2'd3, 8'h73);
    wait_idle("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
